// File: rtl/icache_direct_pkg.sv
// Shared types and default geometry for the direct-mapped instruction cache.
package icache_direct_pkg;

    localparam int ICACHE_LINES = 64;
    localparam int ICACHE_WORDS = 4;

    typedef enum logic [1:0] {
        IC_IDLE = 2'd0,
        IC_REQ  = 2'd1,
        IC_FILL = 2'd2
    } IcacheState;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } IcacheMemReq;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } IcacheMemResp;

endpackage

// File: rtl/icache_direct_if.sv
// Fetch-port and refill-bus signal bundle; slave = cache side, master = pipeline/memory side.
interface icache_direct_if;

    logic        req_valid;
    logic [31:0] req_addr;
    logic        res_valid;
    logic [31:0] res_data;
    logic        cmiss_stall;
    logic        flush;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    modport slave (
        input  req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
        output res_valid, res_data, cmiss_stall, mem_req_valid, mem_req_addr
    );

    modport master (
        output req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
        input  res_valid, res_data, cmiss_stall, mem_req_valid, mem_req_addr
    );

endinterface

// File: rtl/icache_direct_line_store.sv
// Cache data array: one combinational read port, one synchronous write port.
module icache_line_store #(
    parameter int LINES  = 64,
    parameter int WORDS  = 4,
    parameter int IDX_W  = $clog2(LINES),
    parameter int WORD_W = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WORD_W-1:0] wr_word,
    input  logic [31:0]       wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [WORD_W-1:0] rd_word,
    output logic [31:0]       rd_data
);

    logic [31:0] mem_q [LINES*WORDS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[{wr_idx, wr_word}] <= wr_data;
        end
    end

    assign rd_data = mem_q[{rd_idx, rd_word}];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache with in-order line refill.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
//
//   state   | meaning
//   IDLE    | lookup; hit served combinationally, miss latches line address
//   REQ     | refill request held on the memory bus until accepted
//   FILL    | one word written per response beat; last beat installs tag/valid
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int LINES          = ICACHE_LINES,
    parameter int WORDS_PER_LINE = ICACHE_WORDS
) (
    input  logic           clk,
    input  logic           reset,
    icache_direct_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]    stat_hits,
    output logic [31:0]    stat_misses
`endif
);

    localparam int WORD_W  = $clog2(WORDS_PER_LINE);
    localparam int IDX_W   = $clog2(LINES);
    localparam int IDX_LSB = 2 + WORD_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    localparam int TAG_W   = 32 - TAG_LSB;

    localparam logic [1:0] ST_IDLE = IC_IDLE;
    localparam logic [1:0] ST_REQ  = IC_REQ;
    localparam logic [1:0] ST_FILL = IC_FILL;

    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(WORDS_PER_LINE - 1);

    logic [1:0]        state_q;
    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q [LINES];
    logic [WORD_W-1:0] beat_q;
    logic              flush_pending_q;
    logic [31:0]       line_addr_q;

    logic [IDX_W-1:0]  req_idx;
    logic [WORD_W-1:0] req_word;
    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [31:0]       rd_data;
    logic              lookup_hit;
    logic              lookup_miss;
    logic              fill_we;
    logic              fill_last;
    IcacheMemReq       mem_req;
    IcacheMemResp      mem_resp;
    logic              unused_addr_bits;

    assign req_word = bus.req_addr[IDX_LSB-1:2];
    assign req_idx  = bus.req_addr[TAG_LSB-1:IDX_LSB];
    assign req_tag  = bus.req_addr[31:TAG_LSB];
    assign fill_idx = line_addr_q[TAG_LSB-1:IDX_LSB];
    assign unused_addr_bits = ^bus.req_addr[1:0];

    assign mem_resp = '{valid: bus.mem_resp_valid, data: bus.mem_resp_data};

    // Outputs are gated by reset so nothing leaks while the cache is held in reset.
    always_comb begin
        lookup_hit  = ~reset && (state_q == ST_IDLE) && bus.req_valid
                      && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
        lookup_miss = ~reset && (state_q == ST_IDLE) && bus.req_valid && !lookup_hit;
        fill_we     = (state_q == ST_FILL) && mem_resp.valid;
        fill_last   = fill_we && (beat_q == LAST_BEAT);
        mem_req.valid = ~reset && (state_q == ST_REQ);
        mem_req.addr  = line_addr_q;
    end

    assign bus.res_valid     = lookup_hit;
    assign bus.res_data      = lookup_hit ? rd_data : 32'h0;
    assign bus.cmiss_stall   = lookup_miss || (~reset && (state_q != ST_IDLE));
    assign bus.mem_req_valid = mem_req.valid;
    assign bus.mem_req_addr  = mem_req.addr;

    icache_line_store #(
        .LINES (LINES),
        .WORDS (WORDS_PER_LINE)
    ) u_line_store (
        .clk     (clk),
        .wr_en   (fill_we),
        .wr_idx  (fill_idx),
        .wr_word (beat_q),
        .wr_data (mem_resp.data),
        .rd_idx  (req_idx),
        .rd_word (req_word),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            valid_q         <= '0;
            beat_q          <= '0;
            flush_pending_q <= 1'b0;
            line_addr_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.flush) begin
                        valid_q <= '0;
                    end
                    if (lookup_miss) begin
                        line_addr_q <= {bus.req_addr[31:IDX_LSB], {IDX_LSB{1'b0}}};
                        state_q     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.flush) begin
                        flush_pending_q <= 1'b1;
                    end
                    if (bus.mem_req_ready) begin
                        beat_q  <= '0;
                        state_q <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (bus.flush) begin
                        flush_pending_q <= 1'b1;
                    end
                    if (fill_we) begin
                        beat_q <= beat_q + WORD_W'(1);
                    end
                    // A flush seen anywhere during the miss invalidates the fresh line too.
                    if (fill_last) begin
                        if (flush_pending_q || bus.flush) begin
                            valid_q <= '0;
                        end else begin
                            valid_q[fill_idx] <= 1'b1;
                        end
                        flush_pending_q <= 1'b0;
                        state_q         <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fill_last) begin
            tag_q[fill_idx] <= line_addr_q[31:TAG_LSB];
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else begin
            if (lookup_hit) begin
                stat_hits <= stat_hits + 32'd1;
            end
            if (lookup_miss) begin
                stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Scoreboard bench for icache_direct: expected fetch data and refill addresses are queued by stimulus.
module tb_icache_direct;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    icache_direct_if bus ();

`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    icache_direct dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef ICACHE_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] res_q [$];
    logic [31:0] req_q [$];
    logic [31:0] beats [4];
    logic [31:0] mon_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beats(input logic [31:0] base);
        for (int b = 0; b < 4; b++) beats[b] = base + 32'(b);
    endtask

    // Monitor: every hit pops an expected word, every accepted request pops an expected line address.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.res_valid) begin
                if (res_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_hit: got %h expected no response at %0t", bus.res_data, $time);
                end else begin
                    mon_exp = res_q.pop_front();
                    chk("res_data", bus.res_data, mon_exp);
                end
            end else begin
                chk("res_data_idle_zero", bus.res_data, 32'h0);
            end
            if (bus.mem_req_valid && bus.mem_req_ready) begin
                if (req_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_mem_req: got %h expected no request at %0t", bus.mem_req_addr, $time);
                end else begin
                    mon_exp = req_q.pop_front();
                    chk("mem_req_addr", bus.mem_req_addr, mon_exp);
                end
            end
        end
    end

    task automatic fetch_hit(input logic [31:0] addr, input logic [31:0] exp);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        res_q.push_back(exp);
        @(negedge clk);
        chk("hit_valid", 32'(bus.res_valid), 32'd1);
        chk("hit_no_stall", 32'(bus.cmiss_stall), 32'd0);
        step();
        bus.req_valid = 1'b0;
    endtask

    // Miss, optional request backpressure, 4-beat refill, optional flush pulse on a given beat.
    task automatic fetch_miss(input logic [31:0] addr, input int delay, input int flush_beat,
                              input bit hit_after, input logic [31:0] exp);
        logic [31:0] line;
        line = {addr[31:4], 4'h0};
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        req_q.push_back(line);
        @(negedge clk);
        chk("miss_stall", 32'(bus.cmiss_stall), 32'd1);
        chk("miss_no_hit", 32'(bus.res_valid), 32'd0);
        step();
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            chk("bp_req_valid", 32'(bus.mem_req_valid), 32'd1);
            chk("bp_req_addr", bus.mem_req_addr, line);
            chk("bp_stall", 32'(bus.cmiss_stall), 32'd1);
            step();
        end
        bus.mem_req_ready = 1'b1;
        @(negedge clk);
        chk("req_valid", 32'(bus.mem_req_valid), 32'd1);
        step();
        bus.mem_req_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = beats[b];
            bus.flush          = (b == flush_beat);
            @(negedge clk);
            chk("fill_stall", 32'(bus.cmiss_stall), 32'd1);
            chk("fill_no_req", 32'(bus.mem_req_valid), 32'd0);
            step();
        end
        bus.mem_resp_valid = 1'b0;
        bus.flush          = 1'b0;
        if (hit_after) begin
            res_q.push_back(exp);
            @(negedge clk);
            chk("turnaround_hit", 32'(bus.res_valid), 32'd1);
            chk("turnaround_no_stall", 32'(bus.cmiss_stall), 32'd0);
            step();
            bus.req_valid = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset              = 1'b1;
        bus.req_valid      = 1'b1;
        bus.req_addr       = 32'h100;
        bus.flush          = 1'b0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = 32'h0;
        @(negedge clk);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_stall", 32'(bus.cmiss_stall), 32'd0);
        chk("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_mem_req_addr", bus.mem_req_addr, 32'h0);
        step();
        step();
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        step();

        // Cold miss then hits on the same line
        beats = '{32'h11, 32'h22, 32'h33, 32'h44};
        fetch_miss(32'h100, 0, -1, 1'b1, 32'h11);
        fetch_hit(32'h10C, 32'h44);
        fetch_hit(32'h104, 32'h22);
        fetch_hit(32'h108, 32'h33);

        // Conflict on index 0x10, then refill 0x100 under 5 cycles of backpressure
        set_beats(32'hA000_0000);
        fetch_miss(32'h500, 0, -1, 1'b1, 32'hA000_0000);
        fetch_hit(32'h50C, 32'hA000_0003);
        set_beats(32'hB000_0000);
        fetch_miss(32'h100, 5, -1, 1'b1, 32'hB000_0000);
        fetch_hit(32'h108, 32'hB000_0002);

        // Flush during beat 2: line completes but is left invalid, so 0x200 misses again
        set_beats(32'hC000_0000);
        fetch_miss(32'h200, 0, 2, 1'b0, 32'h0);
        set_beats(32'hD000_0000);
        fetch_miss(32'h200, 0, -1, 1'b1, 32'hD000_0000);
        set_beats(32'hE000_0000);
        fetch_miss(32'h104, 0, -1, 1'b1, 32'hE000_0001);

        // Flush in IDLE: lookup that cycle still hits, next one misses
        bus.flush = 1'b1;
        fetch_hit(32'h204, 32'hD000_0001);
        bus.flush = 1'b0;
        set_beats(32'hF000_0000);
        fetch_miss(32'h204, 0, -1, 1'b1, 32'hF000_0001);
        set_beats(32'h1200_0000);
        fetch_miss(32'h108, 0, -1, 1'b1, 32'h1200_0002);

        // Reset during beat 1 of a 0x300 refill; stray beats afterwards must do nothing
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h300;
        req_q.push_back(32'h300);
        step();
        bus.mem_req_ready = 1'b1;
        step();
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'h3000_0000;
        step();
        bus.mem_resp_data = 32'h3000_0001;
        reset             = 1'b1;
        @(negedge clk);
        chk("rstfill_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rstfill_stall", 32'(bus.cmiss_stall), 32'd0);
        step();
        reset         = 1'b0;
        bus.req_valid = 1'b0;
        bus.mem_resp_data = 32'h3000_0002;
        @(negedge clk);
        chk("stray_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("stray_stall", 32'(bus.cmiss_stall), 32'd0);
        step();
        bus.mem_resp_data = 32'h3000_0003;
        step();
        bus.mem_resp_valid = 1'b0;
        set_beats(32'h4400_0000);
        fetch_miss(32'h100, 0, -1, 1'b1, 32'h4400_0000);

`ifdef ICACHE_STATS_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        set_beats(32'h5500_0000);
        fetch_miss(32'h100, 0, -1, 1'b1, 32'h5500_0000);
        fetch_hit(32'h104, 32'h5500_0001);
        fetch_hit(32'h10C, 32'h5500_0003);
        chk("stat_misses", stat_misses, 32'd1);
        chk("stat_hits", stat_hits, 32'd3);
`endif

        step();
        chk("res_queue_drained", 32'(res_q.size()), 32'd0);
        chk("req_queue_drained", 32'(req_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
